sram_wait_responder: RTL and testbench
======================================

SRAM_WAIT_RESPONDER -- requirements
Module: sram_wait_responder

Interface
REQ-001 Parameter ADDR_W, default 14, address width.
REQ-002 Parameter DATA_W, default 16, data bus width.
REQ-003 Parameter DEPTH, default 16384, number of storage words; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 2, wait states inserted before each response; legal range 0..15.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-007 re  input  1  read request from the memory interface initiator.
REQ-008 we  input  1  write request from the memory interface initiator.
REQ-009 addr  input  ADDR_W  word address, valid while re or we is high.
REQ-010 data  inout  DATA_W  shared bus: initiator drives write data; block drives read data.
REQ-011 mem_resp  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high while a transaction is in progress.
REQ-013 err  output  1  one-cycle protocol-error pulse.

Function
REQ-014 The block SHALL implement four states: IDLE, WAIT, RESP and HOLD.
REQ-015 IDLE: exactly one of re or we high at a clk edge SHALL latch addr, the operation type and, for we, the value on data; the next state SHALL be WAIT, or RESP when WAIT_CYCLES=0.
REQ-016 WAIT: a 4-bit counter SHALL count WAIT_CYCLES cycles, then the block SHALL enter RESP.
REQ-017 RESP: mem_resp SHALL be 1 for exactly this one cycle.
REQ-018 RESP, write: the latched data SHALL be written to the array at the latched address at the end of the RESP cycle.
REQ-019 RESP, read: the block SHALL drive data with the array word at the latched address.
REQ-020 The block SHALL drive data only in RESP of a read; in every other cycle data SHALL be high-Z.
REQ-021 Latency: a request sampled at edge T SHALL produce mem_resp high in cycle T+1+WAIT_CYCLES.
REQ-022 HOLD: the block SHALL remain in HOLD until re=0 and we=0 at a clk edge, then return to IDLE.
REQ-023 HOLD: requests still asserted in HOLD SHALL be ignored, so a held request does not start a second transaction.
REQ-024 Changes on re, we, addr or data during WAIT, RESP or HOLD SHALL NOT affect the active transaction.
REQ-025 re=1 and we=1 together in IDLE SHALL pulse err for one cycle, leave the state in IDLE, leave the array unchanged and produce no mem_resp.
REQ-026 Latched address >= DEPTH: a read SHALL return 0; a write SHALL be dropped; mem_resp SHALL still pulse.
REQ-027 busy SHALL be 1 in WAIT, RESP and HOLD, and 0 in IDLE.
REQ-028 Back-to-back operation: the earliest next request SHALL be sampled on the edge after the return to IDLE, giving a minimum spacing of WAIT_CYCLES+3 cycles.

Reset
REQ-029 reset=1 SHALL force the state to IDLE, the counter to 0, mem_resp=0, busy=0, err=0 and data to high-Z on the next edge.
REQ-030 reset asserted during WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-031 Array contents SHALL NOT be cleared by reset.
REQ-032 re and we SHALL be ignored in any cycle where reset=1.

Verification
REQ-033 Write then read, WAIT_CYCLES=2: we=1 with addr=0x0010 and data=0xBEEF at T -> mem_resp at T+3; a later read of 0x0010 -> data=0xBEEF during its mem_resp cycle, high-Z otherwise.
REQ-034 Held request: re held high for 10 cycles -> exactly one mem_resp pulse, busy stays 1 until the cycle after re drops.
REQ-035 Conflict: re=we=1 in IDLE -> err pulse 1 cycle, no mem_resp, busy=0, array unchanged.
REQ-036 Reset abort: write 0x1234 to 0x0005 (old value 0xAAAA) with reset pulsed in WAIT -> all outputs 0, data high-Z, a later read of 0x0005 returns 0xAAAA.
REQ-037 Out of range, DEPTH=1024: read of 0x0400 -> mem_resp with data=0x0000; write of 0x0400 -> mem_resp, no array word changes.
REQ-038 WAIT_CYCLES=0: request at T -> mem_resp at T+1; back-to-back reads spaced 3 cycles apart both complete correctly.

Source files
------------

// File: rtl/sram_wait_responder.sv
// Single-port SRAM model answering re/we requests after WAIT_CYCLES wait states.
// Read data goes onto the shared bus only during the RESP cycle. A request still held after RESP parks the block in HOLD.
module sram_wait_responder #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              mem_resp,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                err_q, err_d;

  logic                drive;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   rdat;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign idx      = addr_q[IDX_W-1:0];
  assign rdat     = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured only on the IDLE accept edge, so later bus activity cannot disturb the transaction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (re && we) begin
          err_d = 1'b1;
        end else if (re || we) begin
          op_we_d = we;
          addr_d  = addr;
          wdat_d  = data;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  if (!re && !we) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    mem_resp = (state_q == S_RESP);
    drive    = (state_q == S_RESP) && !op_we_q;
  end

  assign err  = err_q;
  assign data = drive ? rdat : {DATA_W{1'bz}};

  // The array has no reset. A reset on the closing edge of RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_RESP && op_we_q && in_range) begin
      mem[idx] <= wdat_q;
    end
  end

endmodule

// File: tb/tb_sram_wait_responder.sv
// Two responders (2 and 0 wait states, 1024 words) share one stimulus stream.
// A transaction-level model predicts their outputs, and directed checks cover the fixed scenarios.
module tb_sram_wait_responder;
  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int DEP = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, re, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] tb_dat;
  logic          oe_a, oe_b;
  wire  [DW-1:0] dbus_a, dbus_b;
  logic          resp_a, busy_a, err_a, resp_b, busy_b, err_b;

  assign dbus_a = oe_a ? tb_dat : {DW{1'bz}};
  assign dbus_b = oe_b ? tb_dat : {DW{1'bz}};

  sram_wait_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .data(dbus_a),
    .mem_resp(resp_a), .busy(busy_a), .err(err_a));

  sram_wait_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .data(dbus_b),
    .mem_resp(resp_b), .busy(busy_b), .err(err_b));

  // Model state: a transaction is just "active since edge start" plus what was latched.
  logic [DW-1:0] m_mem   [2][DEP];
  bit            m_known [2][DEP];
  bit            m_act [2];
  int            m_start [2];
  bit            m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd [2];
  bit            e_resp [2], e_busy [2], e_err [2], e_drive [2], e_known [2];
  logic [DW-1:0] e_rdat [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  function automatic int wc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_step(int i);
    e_err[i] = 1'b0;
    if (reset) begin
      m_act[i] = 1'b0;
    end else if (!m_act[i]) begin
      if (re && we) begin
        e_err[i] = 1'b1;
      end else if (re || we) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc;
        m_we[i]    = we;
        m_addr[i]  = addr;
        m_wd[i]    = tb_dat;
      end
    end else begin
      if (cyc == m_start[i] + wc(i) + 1 && m_we[i] && m_addr[i] < DEP) begin
        m_mem[i][m_addr[i][9:0]]   = m_wd[i];
        m_known[i][m_addr[i][9:0]] = 1'b1;
      end
      if (cyc >= m_start[i] + wc(i) + 2 && !re && !we) m_act[i] = 1'b0;
    end
    e_busy[i]  = m_act[i];
    e_resp[i]  = m_act[i] && (cyc == m_start[i] + wc(i));
    e_drive[i] = e_resp[i] && !m_we[i];
    if (m_addr[i] < DEP) begin
      e_rdat[i]  = m_mem[i][m_addr[i][9:0]];
      e_known[i] = m_known[i][m_addr[i][9:0]];
    end else begin
      e_rdat[i]  = '0;
      e_known[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    oe_a = !e_drive[0];
    oe_b = !e_drive[1];
    #1;
    cyc++;
  endtask

  task automatic run_txn(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat_a, output int lat_b, output int pul_a, output int pul_b,
                         output logic [DW-1:0] rd_a, output logic [DW-1:0] rd_b);
    re = r; we = w; addr = a; tb_dat = d;
    lat_a = -1; lat_b = -1; pul_a = 0; pul_b = 0; rd_a = '0; rd_b = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (resp_a) begin if (lat_a < 0) lat_a = k; pul_a++; rd_a = dbus_a; end
      if (resp_b) begin if (lat_b < 0) lat_b = k; pul_b++; rd_b = dbus_b; end
      if (k == 0) begin re = 1'b0; we = 1'b0; addr = AW'($urandom); tb_dat = DW'($urandom); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; re = 1'b1; we = 1'b0; addr = '0; tb_dat = 16'h5A5A;
    tick(); tick();
    total++; if ({resp_a, busy_a, err_a} !== 3'b000) begin bad++; $display("FAIL reset_out_a got=%b want=000", {resp_a, busy_a, err_a}); end
    total++; if ({resp_b, busy_b, err_b} !== 3'b000) begin bad++; $display("FAIL reset_out_b got=%b want=000", {resp_b, busy_b, err_b}); end
    total++; if (dbus_a !== tb_dat) begin bad++; $display("FAIL reset_bus_a got=%h want=%h", dbus_a, tb_dat); end
    re = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int la, lb, pa, pb; logic [DW-1:0] ra, rb;
    run_txn(1'b0, 1'b1, 14'h0010, 16'hBEEF, la, lb, pa, pb, ra, rb);
    total++; if (la != 2) begin bad++; $display("FAIL wr_lat_a got=%0d want=2", la); end
    total++; if (lb != 0) begin bad++; $display("FAIL wr_lat_b got=%0d want=0", lb); end
    total++; if (pa != 1 || pb != 1) begin bad++; $display("FAIL wr_pulses got=%0d/%0d want=1/1", pa, pb); end
    run_txn(1'b1, 1'b0, 14'h0010, DW'($urandom), la, lb, pa, pb, ra, rb);
    total++; if (ra !== 16'hBEEF) begin bad++; $display("FAIL rd_data_a got=%h want=beef", ra); end
    total++; if (rb !== 16'hBEEF) begin bad++; $display("FAIL rd_data_b got=%h want=beef", rb); end
    total++; if (la != 2) begin bad++; $display("FAIL rd_lat_a got=%0d want=2", la); end
  endtask

  task automatic test_conflict();
    int la, lb, pa, pb; logic [DW-1:0] ra, rb;
    re = 1'b1; we = 1'b1; addr = 14'h0010; tb_dat = 16'h1111;
    tick();
    total++; if ({resp_a, busy_a, err_a} !== 3'b001) begin bad++; $display("FAIL conf_a got=%b want=001", {resp_a, busy_a, err_a}); end
    total++; if ({resp_b, busy_b, err_b} !== 3'b001) begin bad++; $display("FAIL conf_b got=%b want=001", {resp_b, busy_b, err_b}); end
    re = 1'b0; we = 1'b0;
    tick();
    total++; if ({err_a, err_b} !== 2'b00) begin bad++; $display("FAIL conf_err_len got=%b want=00", {err_a, err_b}); end
    run_txn(1'b1, 1'b0, 14'h0010, 16'h0, la, lb, pa, pb, ra, rb);
    total++; if (ra !== 16'hBEEF || rb !== 16'hBEEF) begin bad++; $display("FAIL conf_array got=%h/%h want=beef", ra, rb); end
  endtask

  task automatic test_reset_abort();
    int la, lb, pa, pb; logic [DW-1:0] ra, rb;
    run_txn(1'b0, 1'b1, 14'h0005, 16'hAAAA, la, lb, pa, pb, ra, rb);
    we = 1'b1; addr = 14'h0005; tb_dat = 16'h1234;
    tick();
    we = 1'b0; reset = 1'b1;
    tick();
    total++; if ({resp_a, busy_a, err_a, resp_b, busy_b, err_b} !== 6'b0) begin bad++; $display("FAIL abort_out got=%b want=000000", {resp_a, busy_a, err_a, resp_b, busy_b, err_b}); end
    total++; if (dbus_a !== tb_dat || dbus_b !== tb_dat) begin bad++; $display("FAIL abort_bus got=%h/%h want=%h", dbus_a, dbus_b, tb_dat); end
    reset = 1'b0;
    tick();
    run_txn(1'b1, 1'b0, 14'h0005, 16'h0, la, lb, pa, pb, ra, rb);
    total++; if (ra !== 16'hAAAA || rb !== 16'hAAAA) begin bad++; $display("FAIL abort_keep got=%h/%h want=aaaa", ra, rb); end
  endtask

  task automatic test_out_of_range();
    int la, lb, pa, pb; logic [DW-1:0] ra, rb;
    run_txn(1'b0, 1'b1, 14'h0000, 16'h0F0F, la, lb, pa, pb, ra, rb);
    run_txn(1'b0, 1'b1, 14'h03FF, 16'h7E57, la, lb, pa, pb, ra, rb);
    run_txn(1'b1, 1'b0, 14'h0400, 16'hFFFF, la, lb, pa, pb, ra, rb);
    total++; if (pa != 1 || pb != 1) begin bad++; $display("FAIL oor_rd_pulse got=%0d/%0d want=1/1", pa, pb); end
    total++; if (ra !== 16'h0 || rb !== 16'h0) begin bad++; $display("FAIL oor_rd_data got=%h/%h want=0000", ra, rb); end
    run_txn(1'b0, 1'b1, 14'h0400, 16'h5555, la, lb, pa, pb, ra, rb);
    total++; if (pa != 1 || pb != 1) begin bad++; $display("FAIL oor_wr_pulse got=%0d/%0d want=1/1", pa, pb); end
    run_txn(1'b1, 1'b0, 14'h0000, 16'h0, la, lb, pa, pb, ra, rb);
    total++; if (ra !== 16'h0F0F || rb !== 16'h0F0F) begin bad++; $display("FAIL oor_alias got=%h/%h want=0f0f", ra, rb); end
    run_txn(1'b1, 1'b0, 14'h03FF, 16'h0, la, lb, pa, pb, ra, rb);
    total++; if (ra !== 16'h7E57 || rb !== 16'h7E57) begin bad++; $display("FAIL top_word got=%h/%h want=7e57", ra, rb); end
  endtask

  task automatic test_held();
    bit ok_a = 1'b1, ok_b = 1'b1;
    int pa = 0, pb = 0;
    re = 1'b1; we = 1'b0; addr = 14'h0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!busy_a) ok_a = 1'b0;
      if (!busy_b) ok_b = 1'b0;
      if (resp_a) pa++;
      if (resp_b) pb++;
      tb_dat = DW'($urandom);
    end
    re = 1'b0;
    tick();
    if (resp_a) pa++;
    if (resp_b) pb++;
    total++; if (!ok_a || !ok_b) begin bad++; $display("FAIL held_busy got=%0d/%0d want=1/1", ok_a, ok_b); end
    total++; if (pa != 1 || pb != 1) begin bad++; $display("FAIL held_pulses got=%0d/%0d want=1/1", pa, pb); end
    total++; if ({busy_a, busy_b} !== 2'b00) begin bad++; $display("FAIL held_release got=%b want=00", {busy_a, busy_b}); end
  endtask

  task automatic b2b(input int gap, output int pa, output int pb, output logic [DW-1:0] la, output logic [DW-1:0] lb);
    pa = 0; pb = 0; la = '0; lb = '0;
    for (int k = 0; k < gap + 8; k++) begin
      re = (k == 0 || k == gap); we = 1'b0;
      addr = (k == 0) ? 14'h0010 : 14'h0005;
      tick();
      if (resp_a) begin pa++; la = dbus_a; end
      if (resp_b) begin pb++; lb = dbus_b; end
    end
  endtask

  task automatic test_back_to_back();
    int pa, pb; logic [DW-1:0] la, lb;
    b2b(3, pa, pb, la, lb);
    total++; if (pb != 2 || lb !== 16'hAAAA) begin bad++; $display("FAIL b2b3_b got=%0d,%h want=2,aaaa", pb, lb); end
    total++; if (pa != 1 || la !== 16'hBEEF) begin bad++; $display("FAIL b2b3_a got=%0d,%h want=1,beef", pa, la); end
    b2b(5, pa, pb, la, lb);
    total++; if (pa != 2 || la !== 16'hAAAA) begin bad++; $display("FAIL b2b5_a got=%0d,%h want=2,aaaa", pa, la); end
    b2b(2, pa, pb, la, lb);
    total++; if (pb != 1 || lb !== 16'hBEEF) begin bad++; $display("FAIL b2b2_b got=%0d,%h want=1,beef", pb, lb); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom % 50 == 0);
      re    = ($urandom % 3 == 0);
      we    = ($urandom % 4 == 0);
      case ($urandom % 6)
        0: addr = 14'h0010;
        1: addr = 14'h0005;
        2: addr = 14'h0000;
        3: addr = 14'h03FF;
        4: addr = 14'h0400;
        default: addr = AW'($urandom);
      endcase
      tb_dat = DW'($urandom);
      tick();
      total++; if ({resp_a, busy_a, err_a} !== {e_resp[0], e_busy[0], e_err[0]}) begin bad++; $display("FAIL rnd_out_a cyc=%0d got=%b want=%b", cyc, {resp_a, busy_a, err_a}, {e_resp[0], e_busy[0], e_err[0]}); end
      total++; if ({resp_b, busy_b, err_b} !== {e_resp[1], e_busy[1], e_err[1]}) begin bad++; $display("FAIL rnd_out_b cyc=%0d got=%b want=%b", cyc, {resp_b, busy_b, err_b}, {e_resp[1], e_busy[1], e_err[1]}); end
      if (e_drive[0] && e_known[0]) begin
        total++; if (dbus_a !== e_rdat[0]) begin bad++; $display("FAIL rnd_rd_a cyc=%0d got=%h want=%h", cyc, dbus_a, e_rdat[0]); end
      end else if (!e_drive[0]) begin
        total++; if (dbus_a !== tb_dat) begin bad++; $display("FAIL rnd_bus_a cyc=%0d got=%h want=%h", cyc, dbus_a, tb_dat); end
      end
      if (e_drive[1] && e_known[1]) begin
        total++; if (dbus_b !== e_rdat[1]) begin bad++; $display("FAIL rnd_rd_b cyc=%0d got=%h want=%h", cyc, dbus_b, e_rdat[1]); end
      end else if (!e_drive[1]) begin
        total++; if (dbus_b !== tb_dat) begin bad++; $display("FAIL rnd_bus_b cyc=%0d got=%h want=%h", cyc, dbus_b, tb_dat); end
      end
    end
    reset = 1'b0; re = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_start[i] = 0; m_we[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0;
      for (int j = 0; j < DEP; j++) begin m_known[i][j] = 1'b0; m_mem[i][j] = '0; end
    end
    reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; tb_dat = '0; oe_a = 1'b1; oe_b = 1'b1;
    test_reset();
    test_write_read();
    test_conflict();
    test_reset_abort();
    test_out_of_range();
    test_held();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
